tmr_multi_ctrl: RTL and testbench

Parametrised control logic for the 8-bit timer subsystem, serving `NUM_CH` timer channels. It sits between the per-channel counter/comparator datapath and the register file. Per channel it produces counter-clear requests, sticky status flags, gated interrupts, a registered TMO waveform with event-driven set/clear/toggle, and an ADC trigger pulse. External TMRI inputs are synchronised and edge-detected on the timer clock.

---
 rtl/tmr_pkg.sv | 64 ++++++
 rtl/tmr_ch_ctrl.sv | 156 +++++++++++++++
 rtl/tmr_multi_ctrl.sv | 77 +++++++
 tb/tb_tmr_multi_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the 8-bit timer control slice: register bit positions,
// per-channel field widths, clear-source and output-action encodings.
package tmr_pkg;

  localparam int REG_W = 8;
  localparam int CTL_W = 5;
  localparam int CLR_W = 3;
  localparam int CS_W  = 5;

  localparam int TCR_CMIEB    = 7;
  localparam int TCR_CMIEA    = 6;
  localparam int TCR_OVIE     = 5;
  localparam int TCR_CCLR_LSB = 3;
  localparam int TCR_CKS_LSB  = 0;

  localparam int TCCR_TMRIS    = 3;
  localparam int TCCR_ICKS_LSB = 0;

  localparam int TCSR_ADTE    = 4;
  localparam int TCSR_OSB_LSB = 2;
  localparam int TCSR_OSA_LSB = 0;

  localparam int FCLR_CMFB = 2;
  localparam int FCLR_CMFA = 1;
  localparam int FCLR_OVF  = 0;

  typedef enum logic [1:0] {
    CCLR_NONE = 2'b00,
    CCLR_A    = 2'b01,
    CCLR_B    = 2'b10,
    CCLR_EXT  = 2'b11
  } cclr_e;

  // The numeric order of the action codes is also their priority order.
  typedef enum logic [1:0] {
    OS_NOP    = 2'b00,
    OS_LOW    = 2'b01,
    OS_HIGH   = 2'b10,
    OS_TOGGLE = 2'b11
  } os_e;

  function automatic os_e os_resolve(input os_e act_a, input os_e act_b);
    os_e res;
    if (act_b > act_a) begin
      res = act_b;
    end else begin
      res = act_a;
    end
    return res;
  endfunction

  function automatic logic os_apply(input os_e act, input logic cur);
    logic res;
    case (act)
      OS_NOP:    res = cur;
      OS_LOW:    res = 1'b0;
      OS_HIGH:   res = 1'b1;
      OS_TOGGLE: res = ~cur;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tmr_ch_ctrl.sv
// One timer channel: TMRI synchroniser and edge detect, counter-clear select,
// sticky status flags with interrupt gating, and the TMO output register.
module tmr_ch_ctrl
  import tmr_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tmri_i,
  input  logic [REG_W-1:0] tcr_i,
  input  logic [REG_W-1:0] tccr_i,
  input  logic [CTL_W-1:0] tcsr_ctl_i,
  input  logic             match_a_i,
  input  logic             match_b_i,
  input  logic             ovf_ev_i,
  input  logic [CLR_W-1:0] flag_clr_i,
  output logic             counter_clear_o,
  output logic             cmfa_o,
  output logic             cmfb_o,
  output logic             ovf_o,
  output logic             cmia_o,
  output logic             cmib_o,
  output logic             ovi_o,
  output logic             tmo_o,
  output logic             adc_term_o,
  output logic [CS_W-1:0]  clock_select_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   cmfa_q, cmfa_d;
  logic                   cmfb_q, cmfb_d;
  logic                   ovf_q, ovf_d;
  logic                   tmo_q, tmo_d;

  logic  tmri_lvl_s;
  logic  tmri_rise_s;
  logic  tmris_s;
  logic  counter_clear_s;
  cclr_e cclr_s;
  os_e   osa_s, osb_s;
  os_e   act_a_s, act_b_s, act_s;
  logic  unused_tccr_s;

  assign cclr_s  = cclr_e'(tcr_i[TCR_CCLR_LSB +: 2]);
  assign tmris_s = tccr_i[TCCR_TMRIS];
  assign osa_s   = os_e'(tcsr_ctl_i[TCSR_OSA_LSB +: 2]);
  assign osb_s   = os_e'(tcsr_ctl_i[TCSR_OSB_LSB +: 2]);

  assign tmri_lvl_s  = sync_q[SYNC_STAGES-1];
  assign tmri_rise_s = tmri_lvl_s & ~hist_q;

  assign unused_tccr_s = ^{tccr_i[7:4], tccr_i[2]};

  // Synchroniser shift and edge-detect history next state.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tmri_i};
    hist_d = tmri_lvl_s;
  end

  // Sticky flags: a set event in the same cycle as its clear strobe wins.
  always_comb begin
    cmfa_d = cmfa_q;
    cmfb_d = cmfb_q;
    ovf_d  = ovf_q;
    if (match_a_i) begin
      cmfa_d = 1'b1;
    end else if (flag_clr_i[FCLR_CMFA]) begin
      cmfa_d = 1'b0;
    end else begin
      cmfa_d = cmfa_q;
    end
    if (match_b_i) begin
      cmfb_d = 1'b1;
    end else if (flag_clr_i[FCLR_CMFB]) begin
      cmfb_d = 1'b0;
    end else begin
      cmfb_d = cmfb_q;
    end
    if (ovf_ev_i) begin
      ovf_d = 1'b1;
    end else if (flag_clr_i[FCLR_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // TMO next state; control changes without a match resolve to OS_NOP.
  always_comb begin
    act_a_s = OS_NOP;
    act_b_s = OS_NOP;
    if (match_a_i) begin
      act_a_s = osa_s;
    end else begin
      act_a_s = OS_NOP;
    end
    if (match_b_i) begin
      act_b_s = osb_s;
    end else begin
      act_b_s = OS_NOP;
    end
    act_s = os_resolve(act_a_s, act_b_s);
    tmo_d = os_apply(act_s, tmo_q);
  end

  // Counter clear source select.
  always_comb begin
    counter_clear_s = 1'b0;
    case (cclr_s)
      CCLR_NONE: counter_clear_s = 1'b0;
      CCLR_A:    counter_clear_s = match_a_i;
      CCLR_B:    counter_clear_s = match_b_i;
      CCLR_EXT: begin
        if (tmris_s) begin
          counter_clear_s = tmri_rise_s;
        end else begin
          counter_clear_s = tmri_lvl_s;
        end
      end
      default:   counter_clear_s = 1'b0;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cmfa_q <= 1'b0;
      cmfb_q <= 1'b0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cmfa_q <= cmfa_d;
      cmfb_q <= cmfb_d;
      ovf_q  <= ovf_d;
      tmo_q  <= tmo_d;
    end
  end

  assign counter_clear_o = counter_clear_s;
  assign cmfa_o          = cmfa_q;
  assign cmfb_o          = cmfb_q;
  assign ovf_o           = ovf_q;
  assign cmia_o          = cmfa_q & tcr_i[TCR_CMIEA];
  assign cmib_o          = cmfb_q & tcr_i[TCR_CMIEB];
  assign ovi_o           = ovf_q & tcr_i[TCR_OVIE];
  assign tmo_o           = tmo_q;
  assign adc_term_o      = match_a_i & tcsr_ctl_i[TCSR_ADTE];
  assign clock_select_o  = {tcr_i[TCR_CKS_LSB +: 3], tccr_i[TCCR_ICKS_LSB +: 2]};

endmodule

// File: rtl/tmr_multi_ctrl.sv
// Multi-channel timer control: one tmr_ch_ctrl per channel plus the shared,
// registered ADC trigger formed from the per-channel compare-match-A terms.
module tmr_multi_ctrl
  import tmr_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       tmri,
  input  logic [REG_W*NUM_CH-1:0] tcr,
  input  logic [REG_W*NUM_CH-1:0] tccr,
  input  logic [CTL_W*NUM_CH-1:0] tcsr_ctl,
  input  logic [NUM_CH-1:0]       match_a,
  input  logic [NUM_CH-1:0]       match_b,
  input  logic [NUM_CH-1:0]       ovf_ev,
  input  logic [CLR_W*NUM_CH-1:0] flag_clr,
  output logic [NUM_CH-1:0]       counter_clear,
  output logic [NUM_CH-1:0]       cmfa,
  output logic [NUM_CH-1:0]       cmfb,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       cmia,
  output logic [NUM_CH-1:0]       cmib,
  output logic [NUM_CH-1:0]       ovi,
  output logic [NUM_CH-1:0]       tmo,
  output logic                    adc_request,
  output logic [CS_W*NUM_CH-1:0]  clock_select
);

  logic [NUM_CH-1:0] adc_term_s;
  logic              adc_request_q, adc_request_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tmr_ch_ctrl #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .tmri_i         (tmri[k]),
      .tcr_i          (tcr[k*REG_W +: REG_W]),
      .tccr_i         (tccr[k*REG_W +: REG_W]),
      .tcsr_ctl_i     (tcsr_ctl[k*CTL_W +: CTL_W]),
      .match_a_i      (match_a[k]),
      .match_b_i      (match_b[k]),
      .ovf_ev_i       (ovf_ev[k]),
      .flag_clr_i     (flag_clr[k*CLR_W +: CLR_W]),
      .counter_clear_o(counter_clear[k]),
      .cmfa_o         (cmfa[k]),
      .cmfb_o         (cmfb[k]),
      .ovf_o          (ovf[k]),
      .cmia_o         (cmia[k]),
      .cmib_o         (cmib[k]),
      .ovi_o          (ovi[k]),
      .tmo_o          (tmo[k]),
      .adc_term_o     (adc_term_s[k]),
      .clock_select_o (clock_select[k*CS_W +: CS_W])
    );
  end

  // Any enabled channel's compare-match A starts the ADC.
  always_comb begin
    adc_request_d = |adc_term_s;
  end

  // ADC trigger register: a single-cycle pulse follows each qualifying match.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_request_q <= 1'b0;
    end else begin
      adc_request_q <= adc_request_d;
    end
  end

  assign adc_request = adc_request_q;

endmodule

// File: tb/tb_tmr_multi_ctrl.sv
// Self-checking bench for tmr_multi_ctrl (4 channels): directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_tmr_multi_ctrl;

  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   tmri, match_a, match_b, ovf_ev;
  logic [8*N-1:0] tcr, tccr;
  logic [5*N-1:0] tcsr_ctl;
  logic [3*N-1:0] flag_clr;
  logic [N-1:0]   counter_clear, cmfa, cmfb, ovf, cmia, cmib, ovi, tmo;
  logic           adc_request;
  logic [5*N-1:0] clock_select;

  int total = 0;
  int bad   = 0;

  // Reference model state: flags, TMO level, ADC pulse, TMRI sample history.
  logic [N-1:0] m_cmfa, m_cmfb, m_ovf, m_tmo;
  logic         m_adc;
  logic [S:0]   m_samp [N];

  tmr_multi_ctrl #(.NUM_CH(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .tmri(tmri), .tcr(tcr), .tccr(tccr), .tcsr_ctl(tcsr_ctl),
    .match_a(match_a), .match_b(match_b), .ovf_ev(ovf_ev), .flag_clr(flag_clr),
    .counter_clear(counter_clear), .cmfa(cmfa), .cmfb(cmfb), .ovf(ovf),
    .cmia(cmia), .cmib(cmib), .ovi(ovi), .tmo(tmo), .adc_request(adc_request),
    .clock_select(clock_select)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_edge();
    logic [1:0] a, b;
    if (rst) begin
      m_cmfa = '0; m_cmfb = '0; m_ovf = '0; m_tmo = '0; m_adc = 1'b0;
      for (int k = 0; k < N; k++) m_samp[k] = '0;
    end else begin
      m_adc = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (match_a[k] && tcsr_ctl[5*k+4]) m_adc = 1'b1;
        if (match_a[k]) m_cmfa[k] = 1'b1; else if (flag_clr[3*k+1]) m_cmfa[k] = 1'b0;
        if (match_b[k]) m_cmfb[k] = 1'b1; else if (flag_clr[3*k+2]) m_cmfb[k] = 1'b0;
        if (ovf_ev[k])  m_ovf[k]  = 1'b1; else if (flag_clr[3*k])   m_ovf[k]  = 1'b0;
        a = match_a[k] ? tcsr_ctl[5*k +: 2]   : 2'b00;
        b = match_b[k] ? tcsr_ctl[5*k+2 +: 2] : 2'b00;
        if (a == 2'b11 || b == 2'b11)      m_tmo[k] = ~m_tmo[k];
        else if (a == 2'b10 || b == 2'b10) m_tmo[k] = 1'b1;
        else if (a == 2'b01 || b == 2'b01) m_tmo[k] = 1'b0;
        m_samp[k] = {m_samp[k][S-1:0], tmri[k]};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [N-1:0] exp_cc();
    logic [N-1:0] r;
    logic lvl, rise;
    r = '0;
    for (int k = 0; k < N; k++) begin
      lvl  = m_samp[k][S-1];
      rise = lvl & ~m_samp[k][S];
      case (tcr[8*k+3 +: 2])
        2'b01:   r[k] = match_a[k];
        2'b10:   r[k] = match_b[k];
        2'b11:   r[k] = tccr[8*k+3] ? rise : lvl;
        default: r[k] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [N-1:0] en_bits(input int pos);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = tcr[8*k+pos];
    return r;
  endfunction

  function automatic logic [5*N-1:0] exp_cs();
    logic [5*N-1:0] r;
    for (int k = 0; k < N; k++) r[5*k +: 5] = {tcr[8*k +: 3], tccr[8*k +: 2]};
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tmri = '0; match_a = '0; match_b = '0; ovf_ev = '0; flag_clr = '0;
    tcr  = {8'hE4, 8'hE3, 8'hE2, 8'hE1};
    tccr = {8'h03, 8'h02, 8'h01, 8'h00};
    tcsr_ctl = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    total++;
    if ({counter_clear, cmfa, cmfb, ovf} !== 16'h0000) begin
      bad++; $display("FAIL reset_flags got=%h want=0000", {counter_clear, cmfa, cmfb, ovf});
    end
    total++;
    if ({cmia, cmib, ovi, tmo, adc_request} !== 17'h00000) begin
      bad++; $display("FAIL reset_irq_tmo_adc got=%h want=0", {cmia, cmib, ovi, tmo, adc_request});
    end
    total++;
    if (clock_select !== 20'h9B924) begin
      bad++; $display("FAIL reset_clock_select got=%h want=9b924", clock_select);
    end
    total++;
    if (clock_select !== exp_cs()) begin
      bad++; $display("FAIL clock_select_model got=%h want=%h", clock_select, exp_cs());
    end
  endtask

  task automatic test_toggle_back_to_back();
    logic exp;
    tcsr_ctl[4:0] = 5'b00011;
    exp = 1'b0;
    for (int c = 0; c < 25; c++) begin
      match_a[0] = (c == 10 || c == 11 || c == 20);
      tick();
      if (match_a[0]) exp = ~exp;
      total++;
      if (tmo[0] !== exp) begin
        bad++; $display("FAIL toggle cycle=%0d got=%b want=%b", c, tmo[0], exp);
      end
    end
    match_a = '0;
    tcsr_ctl = '0;
  endtask

  task automatic test_priority();
    total++;
    if (tmo[1] !== 1'b0) begin
      bad++; $display("FAIL prio_start got=%b want=0", tmo[1]);
    end
    tcsr_ctl[9:5] = 5'b01101; match_a[1] = 1'b1; match_b[1] = 1'b1;
    tick();
    total++;
    if (tmo[1] !== 1'b1) begin
      bad++; $display("FAIL prio_toggle_over_low got=%b want=1", tmo[1]);
    end
    tcsr_ctl[9:5] = 5'b00001; match_b[1] = 1'b0;
    tick();
    total++;
    if (tmo[1] !== 1'b0) begin
      bad++; $display("FAIL prio_drive_low got=%b want=0", tmo[1]);
    end
    tcsr_ctl[9:5] = 5'b01001; match_b[1] = 1'b1;
    tick();
    total++;
    if (tmo[1] !== 1'b1) begin
      bad++; $display("FAIL prio_high_over_low got=%b want=1", tmo[1]);
    end
    tcsr_ctl[9:5] = 5'b00000;
    tick();
    total++;
    if (tmo[1] !== 1'b1) begin
      bad++; $display("FAIL prio_nop_hold got=%b want=1", tmo[1]);
    end
    match_a = '0; match_b = '0; tcsr_ctl[9:5] = 5'b01111;
    tick(); tick();
    total++;
    if (tmo[1] !== 1'b1) begin
      bad++; $display("FAIL ctrl_change_no_glitch got=%b want=1", tmo[1]);
    end
    tcsr_ctl = '0;
  endtask

  task automatic test_flags();
    match_a[2] = 1'b1; flag_clr[7] = 1'b1;
    tick();
    match_a = '0; flag_clr = '0;
    total++;
    if ({cmfa[2], cmia[2]} !== 2'b11) begin
      bad++; $display("FAIL set_wins got=%b want=11", {cmfa[2], cmia[2]});
    end
    tick();
    total++;
    if ({cmfa[2], cmia[2]} !== 2'b11) begin
      bad++; $display("FAIL flag_sticky got=%b want=11", {cmfa[2], cmia[2]});
    end
    flag_clr[7] = 1'b1;
    tick();
    flag_clr = '0;
    total++;
    if ({cmfa[2], cmia[2]} !== 2'b00) begin
      bad++; $display("FAIL lone_clear got=%b want=00", {cmfa[2], cmia[2]});
    end
    ovf_ev[2] = 1'b1;
    tick();
    ovf_ev = '0;
    total++;
    if ({ovf[2], ovi[2]} !== 2'b11) begin
      bad++; $display("FAIL ovf_set got=%b want=11", {ovf[2], ovi[2]});
    end
    flag_clr[6] = 1'b1; match_b[2] = 1'b1; flag_clr[8] = 1'b1;
    tick();
    flag_clr = '0; match_b = '0;
    total++;
    if ({ovf[2], ovi[2], cmfb[2], cmib[2]} !== 4'b0011) begin
      bad++; $display("FAIL ovf_clr_cmfb_set got=%b want=0011", {ovf[2], ovi[2], cmfb[2], cmib[2]});
    end
    tcr[8*2+7] = 1'b0;
    #1;
    total++;
    if ({cmfb[2], cmib[2]} !== 2'b10) begin
      bad++; $display("FAIL cmib_gate got=%b want=10", {cmfb[2], cmib[2]});
    end
    tcr[8*2+7] = 1'b1;
  endtask

  task automatic test_tmri();
    logic [N-1:0] e;
    int pulses, first;
    tcr[31:24] = 8'hFC; tccr[31:24] = 8'h0B;
    pulses = 0; first = -1;
    for (int i = 0; i < 12; i++) begin
      tmri[3] = (i < 5);
      tick();
      e = exp_cc();
      total++;
      if (counter_clear[3] !== e[3]) begin
        bad++; $display("FAIL tmri_rise_clr i=%0d got=%b want=%b", i, counter_clear[3], e[3]);
      end
      if (counter_clear[3] === 1'b1) begin
        pulses++;
        if (first < 0) first = i + 1;
      end
    end
    total++;
    if (pulses != 1 || first != S) begin
      bad++; $display("FAIL tmri_rise_pulse got=%0d@%0d want=1@%0d", pulses, first, S);
    end
    tccr[31:24] = 8'h03;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tmri[3] = (i < 5);
      tick();
      e = exp_cc();
      total++;
      if (counter_clear[3] !== e[3]) begin
        bad++; $display("FAIL tmri_lvl_clr i=%0d got=%b want=%b", i, counter_clear[3], e[3]);
      end
      if (counter_clear[3] === 1'b1) pulses++;
    end
    total++;
    if (pulses != 5) begin
      bad++; $display("FAIL tmri_lvl_width got=%0d want=5", pulses);
    end
    tcr[31:24] = 8'hE4;
  endtask

  task automatic test_adc();
    int pulses;
    tcsr_ctl = '0; tcsr_ctl[4] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      match_a = (i == 0) ? 4'b0001 : ((i == 3) ? 4'b0010 : 4'b0000);
      tick();
      total++;
      if (adc_request !== (i == 0)) begin
        bad++; $display("FAIL adc_pulse i=%0d got=%b want=%b", i, adc_request, (i == 0));
      end
      if (adc_request === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL adc_count got=%0d want=1", pulses);
    end
    match_a = '0; tcsr_ctl = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] e;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      tcr      = 32'($urandom);
      tccr     = 32'($urandom);
      tcsr_ctl = 20'($urandom);
      match_a  = N'($urandom) & N'($urandom);
      match_b  = N'($urandom) & N'($urandom);
      ovf_ev   = N'($urandom) & N'($urandom);
      flag_clr = 12'($urandom) & 12'($urandom);
      tmri     = tmri ^ (N'($urandom) & N'($urandom));
      #1;
      e = exp_cc();
      total++;
      if (counter_clear !== e) begin
        bad++; $display("FAIL rnd_clear_pre i=%0d got=%b want=%b", i, counter_clear, e);
      end
      total++;
      if (clock_select !== exp_cs()) begin
        bad++; $display("FAIL rnd_clock_select i=%0d got=%h want=%h", i, clock_select, exp_cs());
      end
      tick();
      total++;
      if ({cmfa, cmfb, ovf} !== {m_cmfa, m_cmfb, m_ovf}) begin
        bad++; $display("FAIL rnd_flags i=%0d got=%h want=%h", i, {cmfa, cmfb, ovf}, {m_cmfa, m_cmfb, m_ovf});
      end
      total++;
      if ({cmia, cmib, ovi} !== {m_cmfa & en_bits(6), m_cmfb & en_bits(7), m_ovf & en_bits(5)}) begin
        bad++; $display("FAIL rnd_irq i=%0d got=%h want=%h", i, {cmia, cmib, ovi},
                        {m_cmfa & en_bits(6), m_cmfb & en_bits(7), m_ovf & en_bits(5)});
      end
      total++;
      if (tmo !== m_tmo) begin
        bad++; $display("FAIL rnd_tmo i=%0d got=%b want=%b", i, tmo, m_tmo);
      end
      total++;
      if (adc_request !== m_adc) begin
        bad++; $display("FAIL rnd_adc i=%0d got=%b want=%b", i, adc_request, m_adc);
      end
      e = exp_cc();
      total++;
      if (counter_clear !== e) begin
        bad++; $display("FAIL rnd_clear_post i=%0d got=%b want=%b", i, counter_clear, e);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle_back_to_back();
    test_priority();
    test_flags();
    test_tmri();
    test_adc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
